cc_psr: RTL and testbench
=========================

CC_PSR -- requirements
Module: cc_psr

Interface
REQ-001 The block SHALL have parameter DATAWIDTH_COND, default 3, meaning the width of the branch-condition select.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, meaning the number of saved-flag entries (power of two, at least 2).
REQ-003 The block SHALL have port CC_PSR_CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port CC_PSR_RESET_InLow  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have ports CC_PSR_negative_InLow, CC_PSR_overflow_InLow, CC_PSR_carry_InLow  input  1 each  ALU flags, active-low.
REQ-006 The block SHALL have port CC_PSR_zero_In  input  1  ALU zero flag, active-high (1 = result zero).
REQ-007 The block SHALL have port CC_PSR_SetCode_In  input  1  ALU set-code qualifier (1 = opcode updates flags).
REQ-008 The block SHALL have port CC_PSR_write_In  input  1  control strobe qualifying a flag update this cycle.
REQ-009 The block SHALL have ports CC_PSR_push_In and CC_PSR_pop_In  input  1 each  save/restore current flags (trap entry/return).
REQ-010 The block SHALL have port CC_PSR_cond_InBus  input  DATAWIDTH_COND  branch condition select.
REQ-011 The block SHALL have port CC_PSR_flags_OutBus  output  4  stored flags {N,Z,V,C}, active-high.
REQ-012 The block SHALL have port CC_PSR_branch_Out  output  1  1 = selected condition true.
REQ-013 The block SHALL have ports CC_PSR_full_Out and CC_PSR_empty_Out  output  1 each  stack status.
REQ-014 The block SHALL have port CC_PSR_error_Out  output  1  sticky; 1 = stack overflow or underflow has occurred.

Function
REQ-015 The flag update SHALL fire when write_In=1, SetCode_In=1, and pop_In=0; on the next edge flags SHALL load {~negative_InLow, zero_In, ~overflow_InLow, ~carry_InLow}.
REQ-016 When write_In=1 and SetCode_In=0, the flags SHALL hold their value.
REQ-017 Flag update latency SHALL be one clock from strobe to flags_OutBus.
REQ-018 branch_Out SHALL be combinational from the stored flags and cond_InBus, with this mapping: 000 never; 001 Z; 010 C; 011 N; 100 V; 101 always; 110 ~Z; 111 N^V.
REQ-019 A push (push_In=1, pop_In=0, not full) SHALL write the current stored flags to the stack top and increment the occupancy count.
REQ-020 When push and flag update occur in the same cycle, the stack SHALL receive the pre-update flags and the register SHALL receive the new flags.
REQ-021 A pop (pop_In=1, push_In=0, not empty) SHALL load flags from the stack top and decrement the count; pop SHALL override any flag update in the same cycle.
REQ-022 When push_In=1 and pop_In=1 together, both SHALL be ignored: stack, flags and error unchanged (a flag update still applies per REQ-015 only if pop_In=0, so none occurs).
REQ-023 A push when full SHALL be ignored and SHALL set error_Out; a pop when empty SHALL be ignored, SHALL leave flags unchanged, and SHALL set error_Out.
REQ-024 full_Out SHALL be 1 when count = STACK_DEPTH; empty_Out SHALL be 1 when count = 0; both SHALL be registered-state derived with no wrap-around of count.
REQ-025 error_Out, once set, SHALL clear only on reset.

Reset
REQ-026 While RESET_InLow=0 at a clock edge: flags SHALL be 4'b0000, count 0, empty_Out 1, full_Out 0, error_Out 0; stack contents SHALL be don't-care.
REQ-027 Reset SHALL take priority over every other input, including a push, pop or flag update in progress the same cycle.

Structure
REQ-028 The condition-code encodings (REQ-018) and flag bit positions SHALL reside in a shared package, for use by the microsequencer.
REQ-029 The stack SHALL be one sub-module, cc_psr_stack (LIFO with push/pop/full/empty/count); the flag register and condition logic SHALL stay in cc_psr.

Verification
REQ-030 Reset, then write=1 with SetCode=1 and inputs N_L=0, Z=0, V_L=1, C_L=0 -> next cycle flags=4'b1001; cond=011 -> branch=1.
REQ-031 write=1 with SetCode=0 and any inputs -> flags unchanged; cond=101 -> branch=1; cond=000 -> branch=0.
REQ-032 Flags=4'b0100, then push in the same cycle as an update to 4'b1000 -> flags=4'b1000, count=1; pop -> flags=4'b0100, empty=1.
REQ-033 Five pushes with STACK_DEPTH=4 -> full=1 after the 4th, error=1 after the 5th, count stays 4; four pops return the saved values in LIFO order.
REQ-034 Pop on empty -> error=1 and flags unchanged; push+pop together -> no change; reset low mid-sequence -> all values per REQ-026 on the next edge.

Source files
------------

// File: rtl/cc_psr_pkg.sv
// Condition-code encodings and flag bit positions shared by the
// PSR block and the microsequencer.
package cc_psr_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  localparam int FLAG_W = 4;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_C      = 3'b010;
  localparam logic [2:0] COND_N      = 3'b011;
  localparam logic [2:0] COND_V      = 3'b100;
  localparam logic [2:0] COND_ALWAYS = 3'b101;
  localparam logic [2:0] COND_NZ     = 3'b110;
  localparam logic [2:0] COND_LT     = 3'b111;

  function automatic logic cond_true(
    input logic [2:0]        sel,
    input logic [FLAG_W-1:0] f
  );
    logic r;
    r = 1'b0;
    unique case (sel)
      COND_NEVER:  r = 1'b0;
      COND_Z:      r = f[FLAG_Z];
      COND_C:      r = f[FLAG_C];
      COND_N:      r = f[FLAG_N];
      COND_V:      r = f[FLAG_V];
      COND_ALWAYS: r = 1'b1;
      COND_NZ:     r = ~f[FLAG_Z];
      COND_LT:     r = f[FLAG_N] ^ f[FLAG_V];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cc_psr_stack.sv
// LIFO holding saved flag words; simultaneous push and pop cancel,
// and pushes when full or pops when empty are dropped.
module cc_psr_stack
  import cc_psr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [FLAG_W-1:0] din,
  output logic [FLAG_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       count_q, count_d;
  logic [FLAG_W-1:0] mem_q [DEPTH];
  logic [FLAG_W-1:0] mem_d [DEPTH];
  logic [AW:0]       top_w;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign top_w   = count_q - {{AW{1'b0}}, 1'b1};
  assign dout    = mem_q[top_w[AW-1:0]];

  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[count_q[AW-1:0]] = din;
      count_d = count_q + {{AW{1'b0}}, 1'b1};
    end else if (pop_ok) begin
      count_d = top_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Stack contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cc_psr.sv
// Processor status register: condition flags, branch condition
// evaluation and a save/restore stack for trap entry and return.
module cc_psr
  import cc_psr_pkg::*;
#(
  parameter int DATAWIDTH_COND = 3,
  parameter int STACK_DEPTH    = 4
) (
  input  logic                      CC_PSR_CLOCK_50,
  input  logic                      CC_PSR_RESET_InLow,
  input  logic                      CC_PSR_negative_InLow,
  input  logic                      CC_PSR_overflow_InLow,
  input  logic                      CC_PSR_carry_InLow,
  input  logic                      CC_PSR_zero_In,
  input  logic                      CC_PSR_SetCode_In,
  input  logic                      CC_PSR_write_In,
  input  logic                      CC_PSR_push_In,
  input  logic                      CC_PSR_pop_In,
  input  logic [DATAWIDTH_COND-1:0] CC_PSR_cond_InBus,
  output logic [3:0]                CC_PSR_flags_OutBus,
  output logic                      CC_PSR_branch_Out,
  output logic                      CC_PSR_full_Out,
  output logic                      CC_PSR_empty_Out,
  output logic                      CC_PSR_error_Out
);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;
  logic              push_only;
  logic              pop_only;
  logic              upd;
  logic [DATAWIDTH_COND+2:0] cond_ext;

  assign push_only = CC_PSR_push_In & ~CC_PSR_pop_In;
  assign pop_only  = CC_PSR_pop_In & ~CC_PSR_push_In;
  assign upd       = CC_PSR_write_In & CC_PSR_SetCode_In
                   & ~CC_PSR_pop_In;

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = ~CC_PSR_negative_InLow;
    alu_flags[FLAG_Z] = CC_PSR_zero_In;
    alu_flags[FLAG_V] = ~CC_PSR_overflow_InLow;
    alu_flags[FLAG_C] = ~CC_PSR_carry_InLow;
  end

  cc_psr_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (CC_PSR_CLOCK_50),
    .rst_n (CC_PSR_RESET_InLow),
    .push  (CC_PSR_push_In),
    .pop   (CC_PSR_pop_In),
    .din   (flags_q),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // A restore wins over any ALU update in the same cycle.
  always_comb begin
    flags_d = flags_q;
    if (pop_only && !stk_empty) flags_d = stk_top;
    else if (upd)               flags_d = alu_flags;
  end

  always_comb begin
    err_d = err_q
          | (push_only & stk_full)
          | (pop_only & stk_empty);
  end

  always_ff @(posedge CC_PSR_CLOCK_50) begin
    if (!CC_PSR_RESET_InLow) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign cond_ext = {3'b000, CC_PSR_cond_InBus};

  assign CC_PSR_flags_OutBus = flags_q;
  assign CC_PSR_branch_Out   = cond_true(cond_ext[2:0], flags_q);
  assign CC_PSR_full_Out     = stk_full;
  assign CC_PSR_empty_Out    = stk_empty;
  assign CC_PSR_error_Out    = err_q;

endmodule

// File: tb/tb_cc_psr.sv
// Self-checking bench for cc_psr against a queue-based model.
module tb_cc_psr;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       n_l, v_l, c_l, z;
  logic       setc, wr, psh, pp;
  logic [2:0] cond;
  logic [3:0] flags;
  logic       br, full, empty, err;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_flags;
  logic [3:0] m_q[$];
  bit         m_err;

  always #5 clk = ~clk;

  cc_psr #(
    .DATAWIDTH_COND (3),
    .STACK_DEPTH    (DEPTH)
  ) dut (
    .CC_PSR_CLOCK_50       (clk),
    .CC_PSR_RESET_InLow    (rst_n),
    .CC_PSR_negative_InLow (n_l),
    .CC_PSR_overflow_InLow (v_l),
    .CC_PSR_carry_InLow    (c_l),
    .CC_PSR_zero_In        (z),
    .CC_PSR_SetCode_In     (setc),
    .CC_PSR_write_In       (wr),
    .CC_PSR_push_In        (psh),
    .CC_PSR_pop_In         (pp),
    .CC_PSR_cond_InBus     (cond),
    .CC_PSR_flags_OutBus   (flags),
    .CC_PSR_branch_Out     (br),
    .CC_PSR_full_Out       (full),
    .CC_PSR_empty_Out      (empty),
    .CC_PSR_error_Out      (err)
  );

  // Branch truth straight from the condition table; f = {N,Z,V,C}.
  function automatic bit ref_br(input logic [2:0] c,
                                input logic [3:0] f);
    case (c)
      3'd0: return 1'b0;
      3'd1: return f[2];
      3'd2: return f[0];
      3'd3: return f[3];
      3'd4: return f[1];
      3'd5: return 1'b1;
      3'd6: return !f[2];
      default: return f[3] != f[1];
    endcase
  endfunction

  // Drive one clock of stimulus and advance the model; nzvc is the
  // active-high flag word the ALU presents.
  task automatic cycle(input bit r, input bit pu, input bit po,
                       input bit w, input bit s,
                       input logic [3:0] nzvc);
    logic [3:0] nxt;
    rst_n = r; psh = pu; pp = po; wr = w; setc = s;
    n_l = ~nzvc[3]; z = nzvc[2]; v_l = ~nzvc[1]; c_l = ~nzvc[0];
    nxt = m_flags;
    if (!r) begin
      nxt = 4'b0000;
      m_q.delete();
      m_err = 1'b0;
    end else begin
      if (w && s && !po) nxt = nzvc;
      if (pu && !po) begin
        if (m_q.size() == DEPTH) m_err = 1'b1;
        else m_q.push_back(m_flags);
      end
      if (po && !pu) begin
        if (m_q.size() == 0) m_err = 1'b1;
        else nxt = m_q.pop_back();
      end
    end
    m_flags = nxt;
    @(posedge clk);
    #1;
    rst_n = 1'b1; psh = 0; pp = 0; wr = 0; setc = 0;
  endtask

  task automatic test_reset();
    cycle(0, 1, 0, 1, 1, 4'hF);
    checks++;
    if (flags !== 4'b0000 || empty !== 1'b1 ||
        full !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: flags=%b e=%b f=%b err=%b want 0000 1 0 0",
               flags, empty, full, err);
    end
  endtask

  task automatic test_update();
    cycle(1, 0, 0, 1, 1, 4'b1001);
    checks++;
    if (flags !== 4'b1001) begin
      errors++;
      $display("FAIL update: flags=%b want 1001", flags);
    end
    cond = 3'b011; #1;
    checks++;
    if (br !== 1'b1) begin
      errors++;
      $display("FAIL br_n: br=%b want 1", br);
    end
  endtask

  task automatic test_hold();
    cycle(1, 0, 0, 1, 0, 4'b0110);
    checks++;
    if (flags !== 4'b1001) begin
      errors++;
      $display("FAIL hold: flags=%b want 1001", flags);
    end
    cond = 3'b101; #1;
    checks++;
    if (br !== 1'b1) begin
      errors++;
      $display("FAIL br_always: br=%b want 1", br);
    end
    cond = 3'b000; #1;
    checks++;
    if (br !== 1'b0) begin
      errors++;
      $display("FAIL br_never: br=%b want 0", br);
    end
  endtask

  task automatic test_push_update();
    cycle(1, 0, 0, 1, 1, 4'b0100);
    cycle(1, 1, 0, 1, 1, 4'b1000);
    checks++;
    if (flags !== 4'b1000 || empty !== 1'b0) begin
      errors++;
      $display("FAIL push_upd: flags=%b e=%b want 1000 0",
               flags, empty);
    end
    cycle(1, 0, 1, 1, 1, 4'b1111);
    checks++;
    if (flags !== 4'b0100 || empty !== 1'b1) begin
      errors++;
      $display("FAIL pop_restore: flags=%b e=%b want 0100 1",
               flags, empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 1, 1, 4'($urandom_range(0, 15)));
      checks++;
      if (full !== (i >= 3) || err !== (i >= 4)) begin
        errors++;
        $display("FAIL push%0d: full=%b err=%b want %b %b",
                 i, full, err, i >= 3, i >= 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 1, 0, 0, 4'h0);
      checks++;
      if (flags !== m_flags || empty !== (i == 3)) begin
        errors++;
        $display("FAIL lifo%0d: flags=%b e=%b want %b %b",
                 i, flags, empty, m_flags, i == 3);
      end
    end
  endtask

  task automatic test_errors();
    cycle(0, 0, 0, 0, 0, 4'h0);
    cycle(1, 0, 0, 1, 1, 4'b0011);
    cycle(1, 0, 1, 1, 1, 4'b1100);
    checks++;
    if (flags !== 4'b0011 || err !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty: flags=%b err=%b e=%b want 0011 1 1",
               flags, err, empty);
    end
    cycle(0, 0, 0, 0, 0, 4'h0);
    cycle(1, 1, 0, 0, 0, 4'h0);
    cycle(1, 1, 1, 1, 1, 4'b1111);
    checks++;
    if (flags !== 4'b0000 || err !== 1'b0 || empty !== 1'b0 ||
        full !== 1'b0) begin
      errors++;
      $display("FAIL push_pop: flags=%b err=%b e=%b f=%b want 0000 0 0 0",
               flags, err, empty, full);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit r, pu, po;
      r  = ($urandom_range(0, 40) != 0);
      pu = ($urandom_range(0, 2) == 0);
      po = ($urandom_range(0, 2) == 0);
      cycle(r, pu, po, 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 15)));
      cond = 3'($urandom_range(0, 7)); #1;
      checks++;
      if (flags !== m_flags || err !== m_err ||
          empty !== (m_q.size() == 0) ||
          full !== (m_q.size() == DEPTH) ||
          br !== ref_br(cond, m_flags)) begin
        errors++;
        $display("FAIL rand%0d: f=%b e=%b fu=%b er=%b br=%b want %b %b %b %b %b",
                 i, flags, empty, full, err, br, m_flags,
                 m_q.size() == 0, m_q.size() == DEPTH, m_err,
                 ref_br(cond, m_flags));
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 1, 0, 1, 1, 4'b1111);
    cycle(1, 1, 0, 1, 1, 4'b0101);
    cycle(0, 0, 1, 1, 1, 4'b1010);
    checks++;
    if (flags !== 4'b0000 || empty !== 1'b1 ||
        full !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b e=%b f=%b err=%b want 0000 1 0 0",
               flags, empty, full, err);
    end
  endtask

  initial begin
    rst_n = 0; n_l = 1; v_l = 1; c_l = 1; z = 0;
    setc = 0; wr = 0; psh = 0; pp = 0; cond = '0;
    m_flags = '0; m_err = 0;
    @(posedge clk); #1;
    test_reset();
    test_update();
    test_hold();
    test_push_update();
    test_overflow();
    test_errors();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
